// File: rtl/key_event_queue.sv
// Turns the scanner's level-style key-down/keycode pair into one debounced event
// per press, held in a small FIFO that the game FSM drains over valid/ready.
module key_event_queue #(
  parameter int DEPTH   = 4,
  parameter int HOLDOFF = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       key_level,
  input  logic [3:0]                 key_code,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [3:0]                 out_code,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(HOLDOFF + 1);

  logic          s1_q, s2_q, s3_q;
  logic [HW-1:0] hold_q, hold_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [3:0]    mem_q [DEPTH];

  logic push_req, push, pop, full;

  assign full     = (count_q == CW'(DEPTH));
  assign push_req = s2_q & ~s3_q & (hold_q == '0);
  assign pop      = (count_q != '0) & out_ready & ~flush;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign push     = push_req & (~full | pop) & ~flush;

  always_comb begin
    hold_d = hold_q;
    if (push_req) begin
      hold_d = HW'(HOLDOFF);
    end else if (hold_q != '0) begin
      hold_d = s2_q ? HW'(HOLDOFF) : hold_q - HW'(1);
    end
  end

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (push_req && full && !pop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      hold_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      s1_q    <= key_level;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      hold_q  <= hold_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'h0;
    end else if (push) begin
      mem_q[wr_q] <= key_code;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_code  = mem_q[rd_q];
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue with DEPTH=4, HOLDOFF=8.
module tb_key_event_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_level;
  logic [3:0] key_code;
  logic       flush;
  logic       out_valid;
  logic [3:0] out_code;
  logic       out_ready;
  logic [2:0] count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  key_event_queue #(.DEPTH(4), .HOLDOFF(8)) dut (
    .clk(clk), .rst_n(rst_n), .key_level(key_level), .key_code(key_code),
    .flush(flush), .out_valid(out_valid), .out_code(out_code),
    .out_ready(out_ready), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code, input int hi, input int lo);
    key_code  = code;
    key_level = 1'b1;
    repeat (hi) tick();
    key_level = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic pop_one(output logic v, output logic [3:0] c);
    v = out_valid;
    c = out_code;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow); end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++; if (out_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL reset_release got v=%0b c=%0d o=%0b want 0/0/0", out_valid, count, overflow);
    end
  endtask

  task automatic test_single();
    key_code  = 4'd7;
    key_level = 1'b1;
    repeat (2) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early got %0b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency got %0b want 1", out_valid); end
    checks++; if (out_code !== 4'd7) begin errors++; $display("FAIL single_code got %0h want 7", out_code); end
    repeat (17) tick();
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_held_count got %0d want 1", count); end
    key_level = 1'b0;
    repeat (12) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL single_pop got c=%0d v=%0b want 0/0", count, out_valid);
    end
  endtask

  task automatic test_bounce();
    logic v; logic [3:0] c;
    key_code  = 4'd5;
    key_level = 1'b1;
    repeat (4) tick();
    key_level = 1'b0;
    repeat (3) tick();
    key_level = 1'b1;
    repeat (5) tick();
    key_level = 1'b0;
    repeat (20) tick();
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL bounce_count got %0d want 1", count); end
    press(4'd9, 4, 12);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL bounce_second got %0d want 2", count); end
    pop_one(v, c);
    checks++; if (v !== 1'b1 || c !== 4'd5) begin errors++; $display("FAIL bounce_pop1 got v=%0b c=%0h want 1/5", v, c); end
    pop_one(v, c);
    checks++; if (v !== 1'b1 || c !== 4'd9) begin errors++; $display("FAIL bounce_pop2 got v=%0b c=%0h want 1/9", v, c); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bounce_empty got %0b want 0", out_valid); end
  endtask

  task automatic test_overflow();
    logic v; logic [3:0] c;
    logic [3:0] exp_codes [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
    for (int i = 0; i < 4; i++) press(exp_codes[i], 4, 12);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before got %0b want 0", overflow); end
    press(4'd6, 4, 12);
    checks++; if (count !== 3'd4 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_full got c=%0d o=%0b want 4/1", count, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      pop_one(v, c);
      checks++; if (v !== 1'b1 || c !== exp_codes[i]) begin
        errors++; $display("FAIL ovf_pop%0d got v=%0b c=%0h want 1/%0h", i, v, c, exp_codes[i]);
      end
    end
    checks++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_drained got v=%0b o=%0b want 0/1", out_valid, overflow);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_flush got %0b want 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic v; logic [3:0] c;
    logic [3:0] exp_codes [4] = '{4'd2, 4'd3, 4'd4, 4'hA};
    for (int i = 1; i <= 4; i++) press(4'(i), 4, 12);
    key_code  = 4'hA;
    key_level = 1'b1;
    repeat (2) tick();
    out_ready = 1'b1;
    c = out_code;
    tick();
    out_ready = 1'b0;
    checks++; if (c !== 4'd1) begin errors++; $display("FAIL fpp_head got %0h want 1", c); end
    checks++; if (count !== 3'd4 || overflow !== 1'b0) begin
      errors++; $display("FAIL fpp_state got c=%0d o=%0b want 4/0", count, overflow);
    end
    repeat (3) tick();
    key_level = 1'b0;
    repeat (12) tick();
    for (int i = 0; i < 4; i++) begin
      pop_one(v, c);
      checks++; if (v !== 1'b1 || c !== exp_codes[i]) begin
        errors++; $display("FAIL fpp_pop%0d got v=%0b c=%0h want 1/%0h", i, v, c, exp_codes[i]);
      end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty got %0b want 0", out_valid); end
  endtask

  task automatic test_flush_reset();
    logic v; logic [3:0] c;
    press(4'd1, 4, 12);
    press(4'd2, 4, 12);
    key_code  = 4'd3;
    key_level = 1'b1;
    repeat (6) tick();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre got %0d want 3", count); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (count !== 3'd0 || overflow !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_clear got c=%0d o=%0b v=%0b want 0/0/0", count, overflow, out_valid);
    end
    repeat (10) tick();
    key_level = 1'b0;
    repeat (6) tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_held got %0d want 0", count); end
    repeat (8) tick();
    press(4'hC, 4, 12);
    checks++; if (count !== 3'd1 || out_code !== 4'hC) begin
      errors++; $display("FAIL flush_after got c=%0d code=%0h want 1/c", count, out_code);
    end
    pop_one(v, c);
    key_code  = 4'hD;
    key_level = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL midrst_in got %0d want 0", count); end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_early got %0b want 0", out_valid); end
    tick();
    checks++; if (count !== 3'd1 || out_code !== 4'hD) begin
      errors++; $display("FAIL midrst_requeue got c=%0d code=%0h want 1/d", count, out_code);
    end
    repeat (10) tick();
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL midrst_once got %0d want 1", count); end
    key_level = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    rst_n = 1'b0; key_level = 1'b0; key_code = 4'h0; flush = 1'b0; out_ready = 1'b0;
    #1;
    test_reset();
    test_single();
    test_bounce();
    test_overflow();
    test_full_push_pop();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
